// File: rtl/legv8_multicycle_ctrl_if.sv
// Control/memory handshake bundle between the LEGv8 multicycle sequencer
// and its datapath + unified memory.
interface legv8_multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             run;
  logic [31:0]      instruction;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             IorD;
  logic             IRWrite;
  logic             PCWrite;
  logic             PCSrc;
  logic             Reg2Loc;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrc;
  logic [1:0]       ALUOp;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retired;

  // Sequencer side
  modport master (
    input  run, instruction, zero, mem_ready,
    output mem_req, IorD, IRWrite, PCWrite, PCSrc, Reg2Loc, MemRead, MemWrite,
           MemtoReg, RegWrite, ALUSrc, ALUOp, trap, trap_cause, retired
  );

  // Datapath / memory side
  modport slave (
    output run, instruction, zero, mem_ready,
    input  mem_req, IorD, IRWrite, PCWrite, PCSrc, Reg2Loc, MemRead, MemWrite,
           MemtoReg, RegWrite, ALUSrc, ALUOp, trap, trap_cause, retired
  );
endinterface

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle control sequencer for the LEGv8 subset (ADD/SUB/AND/ORR,
// LDUR, STUR, CBZ) sharing one memory port between fetch and data access.
module legv8_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic clk,
  input  logic reset_n,
  legv8_multicycle_ctrl_if.master bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_LD, CL_ST, CL_CBZ, CL_ILL
  } cls_t;

  state_t             state_q, state_d;
  cls_t               cls_q, cls_d, dec_cls;
  logic [1:0]         cause_q, cause_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [10:0]        opcode;
  logic               timeout;
  logic               unused_ok;

  logic mem_req, iord, irwrite, pcwrite, pcsrc, reg2loc, memread, memwrite;
  logic memtoreg, regwrite, alusrc, trap;
  logic [1:0] aluop;

  assign opcode    = bus.instruction[31:21];
  assign unused_ok = ^bus.instruction[20:0];
  // wait_q holds cycles already waited; this cycle would be the last allowed one
  assign timeout   = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Opcode classification
  always_comb begin
    dec_cls = CL_ILL;
    case (opcode)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: dec_cls = CL_R;
      11'b11111000010:                  dec_cls = CL_LD;
      11'b11111000000:                  dec_cls = CL_ST;
      default: if (opcode[10:3] == 8'b10110100) dec_cls = CL_CBZ;
    endcase
  end

  // State, latched class, trap cause, wait counter and retire counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cls_q     <= CL_ILL;
      cause_q   <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and per-phase control outputs
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cause_d   = cause_q;
    wait_d    = '0;
    retired_d = retired_q;
    mem_req   = 1'b0;
    iord      = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    pcsrc     = 1'b0;
    reg2loc   = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrc    = 1'b0;
    aluop     = 2'b00;
    trap      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        memread = 1'b1;
        if (bus.mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          cause_d = 2'b10;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        reg2loc = (dec_cls == CL_ST) || (dec_cls == CL_CBZ);
        if (dec_cls == CL_ILL) begin
          cause_d = 2'b01;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CL_R: begin
            aluop   = 2'b10;
            state_d = S_WB;
          end
          CL_LD, CL_ST: begin
            alusrc  = 1'b1;
            reg2loc = (cls_q == CL_ST);
            state_d = S_MEM;
          end
          CL_CBZ: begin
            reg2loc   = 1'b1;
            aluop     = 2'b01;
            pcwrite   = bus.zero;
            pcsrc     = bus.zero;
            retired_d = retired_q + 1'b1;
            state_d   = bus.run ? S_FETCH : S_IDLE;
          end
          default: begin
            cause_d = 2'b01;
            state_d = S_TRAP;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        alusrc   = 1'b1;
        memread  = (cls_q == CL_LD);
        memwrite = (cls_q != CL_LD);
        if (bus.mem_ready) begin
          if (cls_q == CL_LD) begin
            state_d = S_WB;
          end else begin
            retired_d = retired_q + 1'b1;
            state_d   = bus.run ? S_FETCH : S_IDLE;
          end
        end else if (timeout) begin
          cause_d = 2'b11;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        regwrite  = 1'b1;
        memtoreg  = (cls_q == CL_LD);
        retired_d = retired_q + 1'b1;
        state_d   = bus.run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req    = mem_req;
  assign bus.IorD       = iord;
  assign bus.IRWrite    = irwrite;
  assign bus.PCWrite    = pcwrite;
  assign bus.PCSrc      = pcsrc;
  assign bus.Reg2Loc    = reg2loc;
  assign bus.MemRead    = memread;
  assign bus.MemWrite   = memwrite;
  assign bus.MemtoReg   = memtoreg;
  assign bus.RegWrite   = regwrite;
  assign bus.ALUSrc     = alusrc;
  assign bus.ALUOp      = aluop;
  assign bus.trap       = trap;
  assign bus.trap_cause = cause_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Randomized self-checking bench: an instruction-level model expands each
// instruction into its expected per-cycle control words and retire count.
module tb_legv8_multicycle_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  localparam logic [15:0] REQ  = 16'h8000, IORD = 16'h4000, IRW  = 16'h2000,
                          PCW  = 16'h1000, PCS  = 16'h0800, R2L  = 16'h0400,
                          MR   = 16'h0200, MW   = 16'h0100, M2R  = 16'h0080,
                          RW   = 16'h0040, ASRC = 16'h0020, OP10 = 16'h0010,
                          OP01 = 16'h0008, TRP  = 16'h0004, C01  = 16'h0001,
                          C10  = 16'h0002, C11  = 16'h0003;

  localparam logic [10:0] LD_OP = 11'b11111000010;
  localparam logic [10:0] ST_OP = 11'b11111000000;

  logic clk = 1'b0;
  logic reset_n;
  logic [15:0] obs;
  logic [CW-1:0] model_ret;
  logic in_idle;
  logic tr;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [10:0] r_ops [4] = '{11'b10001011000, 11'b11001011000,
                             11'b10001010000, 11'b10101010000};

  legv8_multicycle_ctrl_if #(.CNT_W(CW)) bus ();

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.mem_req, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSrc,
                bus.Reg2Loc, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrc, bus.ALUOp, bus.trap, bus.trap_cause};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit is_r(input logic [10:0] op);
    foreach (r_ops[i]) if (r_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_legal(input logic [10:0] op);
    return is_r(op) || op == LD_OP || op == ST_OP || op[10:3] == 8'hB4;
  endfunction

  // One clock cycle: drive mem_ready, check controls mid-cycle, advance
  task automatic step(input string tag, input logic rdy, input logic [15:0] exp);
    bus.mem_ready = rdy;
    @(negedge clk);
    chk(tag, 32'(obs), 32'(exp));
    chk({tag, "_ret"}, 32'(bus.retired), 32'(model_ret));
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic run_after);
    model_ret = model_ret + 1'b1;
    in_idle   = !run_after;
  endtask

  task automatic trap_hold(input logic [15:0] cause);
    repeat (10) begin
      bus.run  = rb();
      bus.zero = rb();
      step("trap", rb(), TRP | cause);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_ctrl", 32'(obs), 32'h0);
    chk("rst_ret", 32'(bus.retired), 32'h0);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    model_ret = '0;
    in_idle   = 1'b1;
    bus.run   = 1'b0;
  endtask

  task automatic enter();
    if (in_idle) begin
      bus.run = 1'b0;
      repeat ($urandom_range(0, 2)) step("idle", rb(), 16'h0);
      bus.run = 1'b1;
      step("idle_go", rb(), 16'h0);
      in_idle = 1'b0;
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction.
  // fd/md: cycles mem_ready stays low before it rises (>= TO means never)
  task automatic do_instr(input logic [31:0] ins, input int unsigned fd,
                          input int unsigned md, input logic z,
                          input logic run_after, output logic trapped);
    logic [10:0] op;
    logic [15:0] w;
    bit r, ld, st, cbz;
    op  = ins[31:21];
    r   = is_r(op);
    ld  = (op == LD_OP);
    st  = (op == ST_OP);
    cbz = (op[10:3] == 8'hB4);
    trapped = 1'b0;
    bus.instruction = ins;
    bus.zero        = z;
    bus.run         = run_after;
    for (int unsigned i = 0; i < fd && i < TO; i++) step("fetch_wait", 1'b0, REQ | MR);
    if (fd >= TO) begin
      trap_hold(C10);
      trapped = 1'b1;
      return;
    end
    step("fetch", 1'b1, REQ | MR | IRW | PCW);
    step("decode", rb(), (st || cbz) ? R2L : 16'h0);
    if (!(r || ld || st || cbz)) begin
      trap_hold(C01);
      trapped = 1'b1;
      return;
    end
    if (cbz) begin
      step("exec_cbz", rb(), R2L | OP01 | (z ? (PCW | PCS) : 16'h0));
      retire(run_after);
      return;
    end
    if (r) begin
      step("exec_r", rb(), OP10);
      step("wb_r", rb(), RW);
      retire(run_after);
      return;
    end
    step("exec_ls", rb(), ASRC | (st ? R2L : 16'h0));
    w = REQ | IORD | ASRC | (ld ? MR : MW);
    for (int unsigned i = 0; i < md && i < TO; i++) step("mem_wait", 1'b0, w);
    if (md >= TO) begin
      trap_hold(C11);
      trapped = 1'b1;
      return;
    end
    step("mem", 1'b1, w);
    if (ld) step("wb_ld", rb(), RW | M2R);
    retire(run_after);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [10:0] op;
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 4 || k == 9) op = r_ops[$urandom_range(0, 3)];
    else if (k == 4) op = LD_OP;
    else if (k == 5) op = ST_OP;
    else if (k < 8) op = {8'hB4, 3'($urandom)};
    else begin
      do op = 11'($urandom); while (is_legal(op));
    end
    return {op, 21'($urandom)};
  endfunction

  function automatic int unsigned rand_delay();
    return ($urandom_range(0, 15) == 0) ? TO : $urandom_range(0, TO - 1);
  endfunction

  initial begin
    reset_n         = 1'b0;
    bus.run         = 1'b0;
    bus.instruction = '0;
    bus.zero        = 1'b0;
    bus.mem_ready   = 1'b0;
    model_ret       = '0;
    in_idle         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_ctrl", 32'(obs), 32'h0);
    chk("init_ret", 32'(bus.retired), 32'h0);
    reset_n = 1'b1;

    enter(); do_instr(32'h8B020020, 1, 0, 1'b0, 1'b1, tr);
    enter(); do_instr(32'hF8408041, 0, 0, 1'b0, 1'b1, tr);
    enter(); do_instr(32'hF8008041, 0, 3, 1'b0, 1'b1, tr);
    enter(); do_instr(32'hB4000040, 0, 0, 1'b1, 1'b1, tr);
    enter(); do_instr(32'hB4000040, 0, 0, 1'b0, 1'b1, tr);
    enter(); do_instr(32'h00000000, 0, 0, 1'b0, 1'b1, tr);
    do_reset();
    enter(); do_instr(32'h8B020020, TO, 0, 1'b0, 1'b1, tr);
    do_reset();
    enter(); do_instr(32'h8B020020, TO - 1, 0, 1'b0, 1'b1, tr);
    for (int i = 0; i < 3; i++) begin
      enter(); do_instr(32'h8B020020, 0, 0, 1'b0, (i != 2), tr);
    end
    enter(); do_instr(32'hF8408041, 0, TO, 1'b0, 1'b1, tr);
    do_reset();
    // counter wrap
    for (int i = 0; i < 17; i++) begin
      enter(); do_instr(32'hCB020020, 0, 0, 1'b0, 1'b1, tr);
    end

    for (int i = 0; i < 200; i++) begin
      enter();
      do_instr(rand_instr(), rand_delay(), rand_delay(), rb(),
               ($urandom_range(0, 3) != 0), tr);
      if (tr) do_reset();
    end

    // Asynchronous reset while a store waits in MEM
    enter();
    bus.instruction = 32'hF8008041;
    bus.run         = 1'b1;
    step("ar_fetch", 1'b1, REQ | MR | IRW | PCW);
    step("ar_decode", 1'b0, R2L);
    step("ar_exec", 1'b0, ASRC | R2L);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("ar_mem", 32'(obs), 32'(REQ | IORD | MW | ASRC));
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_drop", 32'(obs), 32'h0);
    chk("ar_ret", 32'(bus.retired), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
